// File: rtl/cache_pkg.sv
// Shared geometry, FSM encoding and line type for the 4-way write-back data cache.
package cache_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int NUM_SETS   = 8;
    localparam int NUM_WAYS   = 4;
    localparam int OFF_W      = 4;
    localparam int IDX_W      = 3;
    localparam int TAG_W      = 9;
    localparam int ADDR_W     = TAG_W + IDX_W + OFF_W;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2,
        ST_RESPOND   = 2'd3
    } state_t;

    // Bytes touched by an access: offset .. min(offset+count-1, 15); size 0 means a full line.
    function automatic logic [LINE_BYTES-1:0] byte_mask(input logic [OFF_W-1:0] off,
                                                         input logic [3:0]       sz);
        logic [4:0]            cnt;
        logic [4:0]            last;
        logic [4:0]            last_clip;
        logic [LINE_BYTES-1:0] m;
        cnt       = (sz == 4'd0) ? 5'd16 : {1'b0, sz};
        last      = {1'b0, off} + cnt - 5'd1;
        last_clip = (last > 5'd15) ? 5'd15 : last;
        for (int k = 0; k < LINE_BYTES; k++) begin
            m[k] = (5'(k) >= {1'b0, off}) && (5'(k) <= last_clip);
        end
        return m;
    endfunction

endpackage

// File: rtl/cache_way_data.sv
// One way of line storage: 8 entries of 128 bits, byte-granular write, combinational read.
module cache_way_data
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic [IDX_W-1:0]      idx,
    input  logic [LINE_BYTES-1:0] we,
    input  line_t                 wdata,
    output line_t                 rdata
);

    line_t mem_r [NUM_SETS];

    // Byte-lane writes into the addressed entry; storage needs no reset since valid bits gate its use.
    always_ff @(posedge clk) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (we[b]) begin
                mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/cache.sv
// Write-back, write-allocate, 4-way set-associative data cache with a line-wide bus.
module cache
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 pre,
    input  logic                 clr,
    input  logic [LINE_BITS-1:0] data_write,
    input  logic                 RW,
    input  logic                 enable,
    input  logic [ADDR_W-1:0]    address,
    input  logic [3:0]           size,
    output logic [LINE_BITS-1:0] data_read,
    output logic                 ready,
    output logic                 BUS_WR,
    output logic                 BUS_EN,
    output logic [ADDR_W-1:0]    BUS_ADDR,
    output logic [LINE_BITS-1:0] BUS_WRITE,
    input  logic                 BUS_R,
    input  logic [LINE_BITS-1:0] BUS_READ
);

    // Either reset pin clears the whole controller.
    logic rst_n_s;
    assign rst_n_s = clr & pre;

    logic [OFF_W-1:0] offset_s;
    logic [IDX_W-1:0] index_s;
    logic [TAG_W-1:0] tag_s;
    assign offset_s = address[OFF_W-1:0];
    assign index_s  = address[OFF_W+IDX_W-1:OFF_W];
    assign tag_s    = address[ADDR_W-1:OFF_W+IDX_W];

    state_t state_r;
    state_t state_nxt_s;

    logic [NUM_WAYS-1:0] valid_r [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_r [NUM_SETS];
    logic [TAG_W-1:0]    tag_r   [NUM_SETS][NUM_WAYS];
    logic [1:0]          ptr_r   [NUM_SETS];

    logic [1:0]       victim_r;
    line_t            data_read_r;
    line_t            bus_write_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic             ready_r;
    logic             bus_en_r;
    logic             bus_wr_r;

    line_t                 line_rd_s [NUM_WAYS];
    logic [LINE_BYTES-1:0] way_we_s  [NUM_WAYS];
    line_t                 way_wdata_s;

    logic [NUM_WAYS-1:0]   hit_vec_s;
    logic                  hit_s;
    logic [1:0]            hit_way_s;
    logic                  has_invalid_s;
    logic [1:0]            first_inv_s;
    logic [1:0]            victim_s;
    logic                  victim_dirty_s;
    logic [LINE_BYTES-1:0] byte_mask_s;
    line_t                 bit_mask_s;
    line_t                 wr_line_s;
    line_t                 rd_data_s;
    logic                  lookup_s;
    logic                  fill_done_s;
    logic                  wb_done_s;

    genvar gw;
    generate
        for (gw = 0; gw < NUM_WAYS; gw++) begin : g_way
            cache_way_data u_way (
                .clk   (clk),
                .idx   (index_s),
                .we    (way_we_s[gw]),
                .wdata (way_wdata_s),
                .rdata (line_rd_s[gw])
            );
        end
    endgenerate

    // Tag compare across all ways of the indexed set; lowest matching way wins.
    always_comb begin
        hit_vec_s = {NUM_WAYS{1'b0}};
        hit_way_s = 2'd0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec_s[w] = valid_r[index_s][w] && (tag_r[index_s][w] == tag_s);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit_way_s = hit_vec_s[w] ? 2'(w) : hit_way_s;
        end
    end

    assign hit_s = |hit_vec_s;

    // Victim choice: first invalid way, otherwise the round-robin pointer of the set.
    always_comb begin
        first_inv_s = 2'd0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            first_inv_s = valid_r[index_s][w] ? first_inv_s : 2'(w);
        end
    end

    assign has_invalid_s  = ~(&valid_r[index_s]);
    assign victim_s       = has_invalid_s ? first_inv_s : ptr_r[index_s];
    assign victim_dirty_s = valid_r[index_s][victim_s] & dirty_r[index_s][victim_s];

    // Byte mask of the access, widened to a bit mask for read extraction.
    always_comb begin
        byte_mask_s = byte_mask(offset_s, size);
        bit_mask_s  = {LINE_BITS{1'b0}};
        for (int k = 0; k < LINE_BYTES; k++) begin
            bit_mask_s[8*k +: 8] = {8{byte_mask_s[k]}};
        end
    end

    // Store data byte 0 lands on line byte 'offset'; load data is right-aligned with zero fill.
    assign wr_line_s = data_write << {offset_s, 3'b000};
    assign rd_data_s = (line_rd_s[hit_way_s] & bit_mask_s) >> {offset_s, 3'b000};

    assign lookup_s    = (state_r == ST_IDLE) && enable;
    assign fill_done_s = (state_r == ST_FILL) && bus_en_r && BUS_R;
    assign wb_done_s   = (state_r == ST_WRITEBACK) && bus_en_r && BUS_R;

    // Way write steering: full-line fill into the victim, or masked store into the hit way.
    always_comb begin
        way_wdata_s = fill_done_s ? BUS_READ : wr_line_s;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (fill_done_s && (victim_r == 2'(w))) begin
                way_we_s[w] = {LINE_BYTES{1'b1}};
            end else if (lookup_s && hit_s && RW && (hit_way_s == 2'(w))) begin
                way_we_s[w] = byte_mask_s;
            end else begin
                way_we_s[w] = {LINE_BYTES{1'b0}};
            end
        end
    end

    // Next-state logic of the controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    if (hit_s) begin
                        state_nxt_s = ST_RESPOND;
                    end else if (victim_dirty_s) begin
                        state_nxt_s = ST_WRITEBACK;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (wb_done_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_WRITEBACK;
                end
            end
            ST_FILL: begin
                if (fill_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_RESPOND: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Per-set metadata: valid/dirty/tag per way and the replacement pointer.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_r[s] <= {NUM_WAYS{1'b0}};
                dirty_r[s] <= {NUM_WAYS{1'b0}};
                ptr_r[s]   <= 2'd0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_r[s][w] <= {TAG_W{1'b0}};
                end
            end
        end else begin
            if (lookup_s && hit_s && RW) begin
                dirty_r[index_s][hit_way_s] <= 1'b1;
            end
            if (lookup_s && !hit_s && !has_invalid_s) begin
                ptr_r[index_s] <= ptr_r[index_s] + 2'd1;
            end
            if (fill_done_s) begin
                valid_r[index_s][victim_r] <= 1'b1;
                dirty_r[index_s][victim_r] <= 1'b0;
                tag_r[index_s][victim_r]   <= tag_s;
            end
        end
    end

    // Registered requester and bus outputs; bus address/data are latched when a miss is detected.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            ready_r     <= 1'b0;
            bus_en_r    <= 1'b0;
            bus_wr_r    <= 1'b0;
            bus_addr_r  <= {ADDR_W{1'b0}};
            bus_write_r <= {LINE_BITS{1'b0}};
            data_read_r <= {LINE_BITS{1'b0}};
            victim_r    <= 2'd0;
        end else begin
            ready_r  <= (state_nxt_s == ST_RESPOND);
            bus_en_r <= (state_nxt_s == ST_WRITEBACK) || (state_nxt_s == ST_FILL);
            if (lookup_s && hit_s && !RW) begin
                data_read_r <= rd_data_s;
            end
            if (lookup_s && !hit_s) begin
                victim_r    <= victim_s;
                bus_wr_r    <= victim_dirty_s;
                bus_write_r <= line_rd_s[victim_s];
                bus_addr_r  <= victim_dirty_s ? {tag_r[index_s][victim_s], index_s, 4'h0}
                                              : {tag_s, index_s, 4'h0};
            end else if (wb_done_s) begin
                bus_wr_r   <= 1'b0;
                bus_addr_r <= {tag_s, index_s, 4'h0};
            end
        end
    end

    assign data_read = data_read_r;
    assign ready     = ready_r;
    assign BUS_EN    = bus_en_r;
    assign BUS_WR    = bus_wr_r;
    assign BUS_ADDR  = bus_addr_r;
    assign BUS_WRITE = bus_write_r;

endmodule

// File: tb/tb_cache.sv
// Scoreboard bench for the cache: directed requests, a bus responder checking transfers,
// and a ready monitor checking load data.
module tb_cache;

    localparam logic [127:0] PAT   = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] LINE0 = 128'hDD0E0D0C123409080706050403020100;
    localparam logic [127:0] LINE1 = 128'h0F0E0D0C0B5609080706050403020100;

    logic         clk;
    logic         pre;
    logic         clr;
    logic [127:0] data_write;
    logic         RW;
    logic         enable;
    logic [15:0]  address;
    logic [3:0]   size;
    logic [127:0] data_read;
    logic         ready;
    logic         BUS_WR;
    logic         BUS_EN;
    logic [15:0]  BUS_ADDR;
    logic [127:0] BUS_WRITE;
    logic         BUS_R;
    logic [127:0] BUS_READ;

    typedef struct {
        string        name;
        logic [127:0] data;
    } rsp_t;

    typedef struct {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] line;
    } bus_t;

    rsp_t         rsp_q[$];
    bus_t         bus_q[$];
    int           compared;
    int           mismatched;
    logic [127:0] last_rd;
    bit           bus_hold;

    cache dut (
        .clk        (clk),
        .pre        (pre),
        .clr        (clr),
        .data_write (data_write),
        .RW         (RW),
        .enable     (enable),
        .address    (address),
        .size       (size),
        .data_read  (data_read),
        .ready      (ready),
        .BUS_WR     (BUS_WR),
        .BUS_EN     (BUS_EN),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_WRITE  (BUS_WRITE),
        .BUS_R      (BUS_R),
        .BUS_READ   (BUS_READ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_bus(input logic wr, input logic [15:0] a, input logic [127:0] line);
        bus_t b;
        b.wr   = wr;
        b.addr = a;
        b.line = line;
        bus_q.push_back(b);
    endtask

    // Issue one request and wait (bounded) for its ready pulse; lat > 0 checks hit latency.
    task automatic issue(input string nm, input logic rw, input logic [15:0] a,
                         input logic [3:0] sz, input logic [127:0] wd,
                         input logic [127:0] rexp, input int lat);
        rsp_t r;
        int   n;
        r.name = nm;
        r.data = rw ? last_rd : rexp;
        if (!rw) last_rd = rexp;
        rsp_q.push_back(r);
        @(negedge clk);
        RW = rw; address = a; size = sz; data_write = wd; enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 300);
        enable = 1'b0;
        if (ready !== 1'b1) begin
            chk({nm, "_timeout"}, 128'd0, 128'd1);
        end else if (lat > 0) begin
            chk({nm, "_latency"}, 128'(n), 128'(lat));
        end
        chk({nm, "_bus_pending"}, 128'(bus_q.size()), 128'd0);
    endtask

    // Ready monitor: pop the expected response and compare load data.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (ready === 1'b1) begin
                chk("ready_bus_idle", {127'd0, BUS_EN}, 128'd0);
                if (rsp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_ready: got ready=1 expected no pending request");
                end else begin
                    r = rsp_q.pop_front();
                    chk(r.name, data_read, r.data);
                end
            end
        end
    end

    // Bus responder: after a short wait, check the transfer against the queue and complete it.
    initial begin
        int   wait_cnt;
        bus_t b;
        BUS_R    = 1'b0;
        BUS_READ = PAT;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (BUS_EN === 1'b1 && !bus_hold) begin
                wait_cnt++;
                if (wait_cnt >= 3) begin
                    if (bus_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_bus: got addr %h wr %b expected no transfer", BUS_ADDR, BUS_WR);
                    end else begin
                        b = bus_q.pop_front();
                        chk("bus_wr", {127'd0, BUS_WR}, {127'd0, b.wr});
                        chk("bus_addr", {112'd0, BUS_ADDR}, {112'd0, b.addr});
                        if (b.wr) chk("bus_line", BUS_WRITE, b.line);
                    end
                    BUS_R = 1'b1;
                    @(negedge clk);
                    BUS_R    = 1'b0;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        compared = 0; mismatched = 0; last_rd = 128'd0; bus_hold = 1'b0;
        clr = 1'b0; pre = 1'b1; enable = 1'b0; RW = 1'b0;
        address = 16'h0000; size = 4'd0; data_write = 128'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {127'd0, ready}, 128'd0);
        chk("rst_bus_en", {127'd0, BUS_EN}, 128'd0);
        chk("rst_bus_wr", {127'd0, BUS_WR}, 128'd0);
        chk("rst_bus_addr", {112'd0, BUS_ADDR}, 128'd0);
        chk("rst_data_read", data_read, 128'd0);
        chk("rst_bus_write", BUS_WRITE, 128'd0);
        clr = 1'b1;

        exp_bus(1'b0, 16'h0000, 128'd0);
        issue("wr_miss_000A", 1'b1, 16'h000A, 4'd2, 128'h1234, 128'd0, 0);
        issue("rd_hit_000A", 1'b0, 16'h000A, 4'd2, 128'd0, 128'h1234, 1);
        exp_bus(1'b0, 16'h0100, 128'd0);
        issue("rd_miss_010B", 1'b0, 16'h010B, 4'd1, 128'd0, 128'h0B, 0);
        issue("wr_hit_010A_a", 1'b1, 16'h010A, 4'd1, 128'h56, 128'd0, 1);
        issue("wr_hit_010A_b", 1'b1, 16'h010A, 4'd1, 128'h56, 128'd0, 1);
        issue("rd_hit_0108", 1'b0, 16'h0108, 4'd4, 128'd0, 128'h0B560908, 1);
        issue("wr_trunc_000F", 1'b1, 16'h000F, 4'd4, 128'hAABBCCDD, 128'd0, 1);
        issue("rd_trunc_000F", 1'b0, 16'h000F, 4'd4, 128'd0, 128'hDD, 1);
        issue("rd_line_0000", 1'b0, 16'h0000, 4'd0, 128'd0, LINE0, 1);

        exp_bus(1'b0, 16'h0080, 128'd0);
        issue("rd_miss_0080", 1'b0, 16'h0080, 4'd1, 128'd0, 128'h00, 0);
        exp_bus(1'b0, 16'h0180, 128'd0);
        issue("rd_miss_0185", 1'b0, 16'h0185, 4'd1, 128'd0, 128'h05, 0);
        exp_bus(1'b1, 16'h0000, LINE0);
        exp_bus(1'b0, 16'h0200, 128'd0);
        issue("rd_evict_0200", 1'b0, 16'h0200, 4'd1, 128'd0, 128'h00, 0);
        exp_bus(1'b1, 16'h0100, LINE1);
        exp_bus(1'b0, 16'h0280, 128'd0);
        issue("rd_evict_0283", 1'b0, 16'h0283, 4'd2, 128'd0, 128'h0403, 0);

        // Reset in the middle of a fill.
        bus_hold = 1'b1;
        @(negedge clk);
        RW = 1'b0; address = 16'h0300; size = 4'd1; enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (BUS_EN !== 1'b1 && n < 50);
        chk("midfill_bus_en_up", {127'd0, BUS_EN}, 128'd1);
        chk("midfill_bus_addr", {112'd0, BUS_ADDR}, 128'h0300);
        #2 clr = 1'b0;
        #1;
        chk("midfill_rst_bus_en", {127'd0, BUS_EN}, 128'd0);
        chk("midfill_rst_ready", {127'd0, ready}, 128'd0);
        chk("midfill_rst_bus_wr", {127'd0, BUS_WR}, 128'd0);
        chk("midfill_rst_data_read", data_read, 128'd0);
        enable = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        bus_hold = 1'b0;
        last_rd = 128'd0;

        exp_bus(1'b0, 16'h0300, 128'd0);
        issue("rd_after_rst_0303", 1'b0, 16'h0303, 4'd1, 128'd0, 128'h03, 0);

        // Preset pin behaves like clear.
        @(negedge clk);
        pre = 1'b0;
        #1;
        chk("pre_data_read", data_read, 128'd0);
        chk("pre_bus_en", {127'd0, BUS_EN}, 128'd0);
        @(negedge clk);
        pre = 1'b1;
        last_rd = 128'd0;
        exp_bus(1'b0, 16'h0000, 128'd0);
        issue("rd_after_pre_000A", 1'b0, 16'h000A, 4'd2, 128'd0, 128'h0B0A, 0);
        issue("rd_hit_again_000A", 1'b0, 16'h000A, 4'd2, 128'd0, 128'h0B0A, 1);

        repeat (5) @(negedge clk);
        chk("final_rsp_queue", 128'(rsp_q.size()), 128'd0);
        chk("final_bus_queue", 128'(bus_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
